seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial pattern detector; next generation of the fixed 1001 detector.
//  Detects a run-time programmable pattern of 1..MAX_W bits on a qualified serial input.
//  Supports overlapping and non-overlapping modes, and counts matches in a saturating counter.
//  Sits on serial bit streams between a bit-source (deserialiser/UART front end) and control logic.
// PARAMETERS
//  MAX_W     16        maximum pattern length in bits (2..32)
//  DEF_PAT   16'h0009  pattern loaded at reset (LSB = last bit received)
//  DEF_LEN   4         pattern length loaded at reset (1..MAX_W)
//  OVERLAP   1         1: bits of a match may start the next match; 0: history flushed after match
//  CNT_W     8         width of match counter
// PORTS
//  clk        in   1                  clock, rising edge
//  reset      in   1                  asynchronous, active-low reset
//  en         in   1                  x is valid this cycle; bit sampled only when en=1
//  x          in   1                  serial data bit
//  cfg_load   in   1                  load cfg_pat/cfg_len this cycle
//  cfg_pat    in   MAX_W              new pattern (LSB = last bit of sequence)
//  cfg_len    in   $clog2(MAX_W+1)    new pattern length
//  clear_cnt  in   1                  synchronous clear of match_cnt
//  out        out  1                  one-cycle match pulse
//  match_cnt  out  CNT_W              saturating count of matches
//  cfg_err    out  1                  sticky: last cfg_load had illegal length
// BEHAVIOUR
//  Reset (reset=0, async): out=0, match_cnt=0, cfg_err=0, history=0, fill=0, pat=DEF_PAT, len=DEF_LEN.
//  History: shift reg MAX_W bits; on edge with en=1: hist<={hist[MAX_W-2:0],x}, fill=min(fill+1,len).
//  Match: en=1 and fill_next>=len and (hist_next & mask(len)) == (pat & mask(len)).
//  out: registered; high for exactly the one cycle after the edge that sampled the final bit.
//    en=0 -> no shift, no fill change, out<=0. Latency: 1 edge from last bit to out.
//  OVERLAP=0: on a match edge fill<=0; the next match needs len fresh bits.
//  OVERLAP=1: fill is unchanged at a match; back-to-back matches allowed (e.g. len=1).
//  match_cnt: +1 on each match edge; saturates at 2^CNT_W-1 (no wrap).
//    clear_cnt has priority: clear and match on same edge -> match_cnt=0; out still pulses.
//  cfg_load (priority over en): legal if 1<=cfg_len<=MAX_W.
//    Legal: pat/len load, hist=0, fill=0, out<=0, cfg_err<=0; the x on that edge is discarded.
//    Illegal: config unchanged, hist/fill untouched, bit (if en) processed normally, cfg_err<=1.
//  match_cnt is not affected by cfg_load.
//  Reset mid-stream: all state cleared immediately; a partial sequence never completes across reset.
//  Pattern bits above len are ignored (masked).
// TESTING
//  T1 defaults, OVERLAP=1, en=1, x=1,0,0,1,0,0,1 -> out pulses after bits 4 and 7; match_cnt=2.
//  T2 OVERLAP=0, same stream -> one pulse after bit 4; x=0,0,1 then adds 2nd -> match_cnt=2 after 10 bits.
//  T3 en toggles 0 between bits of 1,0,0,1 -> one pulse only after en-qualified 4th bit; no pulses on en=0 cycles.
//  T4 cfg_load pat=3'b101 len=3, stream 1,0,1,0,1 -> pulses after bits 3 and 5; cfg_len=0 load -> cfg_err=1, pattern kept.
//  T5 CNT_W=2, 5 matches -> match_cnt saturates at 3; clear_cnt coincident with match -> match_cnt=0, out=1.
//  T6 reset low after 1,0,0, release, x=1 -> no pulse; full 1,0,0,1 afterward -> pulse, match_cnt=1.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector with a saturating match counter
// History shifts in LSB-first order, so pat[0] is the last bit of the sequence.
module seq_detector_param #(
    parameter int               MAX_W   = 16,
    parameter logic [MAX_W-1:0] DEF_PAT = 16'h0009,
    parameter int               DEF_LEN = 4,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8,
    localparam int              LW      = $clog2(MAX_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [MAX_W-1:0] cfg_pat,
    input  logic [LW-1:0]    cfg_len,
    input  logic             clear_cnt,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_W);
    logic [MAX_W-1:0] hist, pat, mask, hist_nx;
    logic [LW-1:0]    len, fill, fill_sat;
    logic [LW:0]      fill_inc;
    logic             load_ok, match;
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_W; i++) mask[i] = LW'(i) < len;
        hist_nx  = {hist[MAX_W-2:0], x};
        fill_inc = {1'b0, fill} + (LW+1)'(1);
        fill_sat = fill_inc > {1'b0, len} ? len : fill_inc[LW-1:0];
        load_ok  = cfg_load && cfg_len != '0 && cfg_len <= MAX_L;
        // A legal load discards the bit on that edge, so it can never complete a match
        match    = en && !load_ok && fill_sat >= len && ((hist_nx ^ pat) & mask) == '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist      <= '0;
            fill      <= '0;
            pat       <= DEF_PAT;
            len       <= LW'(DEF_LEN);
            out       <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            if (load_ok) begin
                pat  <= cfg_pat;
                len  <= cfg_len;
                hist <= '0;
                fill <= '0;
            end else if (en) begin
                hist <= hist_nx;
                fill <= (match && OVERLAP == 0) ? '0 : fill_sat;
            end
            out       <= match;
            cfg_err   <= cfg_load ? !load_ok : cfg_err;
            match_cnt <= clear_cnt ? '0 : (match && match_cnt != '1) ? match_cnt + CNT_W'(1) : match_cnt;
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed checks of three detector variants (overlap, non-overlap, 2-bit counter)
// All variants share stimulus; expected pulse patterns are hand-derived per variant.
module tb_seq_detector_param;
    localparam int LW = 5;
    logic          clk = 0, reset = 0, en = 0, x = 0, cfg_load = 0, clear_cnt = 0;
    logic [15:0]   cfg_pat = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          out_a, out_b, out_c, err_a, err_b, err_c;
    logic [7:0]    cnt_a, cnt_b;
    logic [1:0]    cnt_c;
    int            total = 0, bad = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.OVERLAP(1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .x(x), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
        .cfg_len(cfg_len), .clear_cnt(clear_cnt), .out(out_a), .match_cnt(cnt_a), .cfg_err(err_a));
    seq_detector_param #(.OVERLAP(0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .x(x), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
        .cfg_len(cfg_len), .clear_cnt(clear_cnt), .out(out_b), .match_cnt(cnt_b), .cfg_err(err_b));
    seq_detector_param #(.OVERLAP(1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .en(en), .x(x), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
        .cfg_len(cfg_len), .clear_cnt(clear_cnt), .out(out_c), .match_cnt(cnt_c), .cfg_err(err_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic b);
        en = e;
        x  = b;
        @(posedge clk);
        #1;
    endtask

    // bits are sent MSB first; ea applies to dut_a and dut_c, eb to dut_b
    task automatic feed(input string tag, input logic [15:0] bits, input int n,
                        input logic [15:0] ea, input logic [15:0] eb);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i]);
            chk($sformatf("%s a%0d", tag, i), out_a, ea[i]);
            chk($sformatf("%s b%0d", tag, i), out_b, eb[i]);
            chk($sformatf("%s c%0d", tag, i), out_c, ea[i]);
        end
    endtask

    initial begin
        logic [3:0] p;
        p = 4'b1001;
        #12;
        chk("rst out", out_a, 0);
        chk("rst cnt", cnt_a, 0);
        chk("rst err", err_a, 0);
        reset = 1;
        feed("t1", 16'b1001001, 7, 16'b0001001, 16'b0001000);
        chk("t1 cnt_a", cnt_a, 2);
        chk("t1 cnt_b", cnt_b, 1);
        chk("t1 cnt_c", cnt_c, 2);
        feed("t2", 16'b001, 3, 16'b001, 16'b001);
        chk("t2 cnt_a", cnt_a, 3);
        chk("t2 cnt_b", cnt_b, 2);
        chk("t2 cnt_c", cnt_c, 3);
        feed("t5", 16'b001, 3, 16'b001, 16'b000);
        chk("t5 sat_c", cnt_c, 3);
        chk("t5 cnt_a", cnt_a, 4);
        chk("t5 cnt_b", cnt_b, 2);
        feed("t5b", 16'b00, 2, 16'b00, 16'b00);
        clear_cnt = 1;
        step(1'b1, 1'b1);
        clear_cnt = 0;
        chk("t5 clr out_a", out_a, 1);
        chk("t5 clr out_b", out_b, 1);
        chk("t5 clr out_c", out_c, 1);
        chk("t5 clr cnt_a", cnt_a, 0);
        chk("t5 clr cnt_b", cnt_b, 0);
        chk("t5 clr cnt_c", cnt_c, 0);
        cfg_load = 1; cfg_pat = 16'h0009; cfg_len = 4;
        step(1'b1, 1'b1);
        cfg_load = 0;
        chk("t3 load out", out_a, 0);
        chk("t3 load err", err_a, 0);
        feed("t3 discard", 16'b001, 3, 16'b000, 16'b000);
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, p[i]);
            chk($sformatf("t3 bit%0d", i), out_a, i == 0);
            step(1'b0, ~p[i]);
            chk($sformatf("t3 idle%0d", i), out_a, 0);
        end
        chk("t3 cnt_a", cnt_a, 1);
        chk("t3 cnt_b", cnt_b, 1);
        cfg_load = 1; cfg_pat = 16'h0005; cfg_len = 3;
        step(1'b1, 1'b1);
        cfg_load = 0;
        feed("t4", 16'b10101, 5, 16'b00101, 16'b00100);
        cfg_load = 1; cfg_pat = 16'hffff; cfg_len = 0;
        step(1'b1, 1'b0);
        cfg_load = 0;
        chk("t4 err len0", err_a, 1);
        chk("t4 ill out", out_a, 0);
        step(1'b1, 1'b1);
        chk("t4 kept a", out_a, 1);
        chk("t4 kept b", out_b, 1);
        chk("t4 err sticky", err_a, 1);
        cfg_load = 1; cfg_len = 17;
        step(1'b0, 1'b0);
        chk("t4 err len17", err_a, 1);
        cfg_pat = 16'h0009; cfg_len = 4;
        step(1'b0, 1'b0);
        cfg_load = 0;
        chk("t4 err clear", err_a, 0);
        chk("t4 cnt_a", cnt_a, 4);
        feed("t6", 16'b100, 3, 16'b000, 16'b000);
        #2 reset = 0;
        #1;
        chk("t6 async out", out_a, 0);
        chk("t6 async cnt", cnt_a, 0);
        #3 reset = 1;
        step(1'b1, 1'b1);
        chk("t6 no cross", out_a, 0);
        feed("t6b", 16'b1001, 4, 16'b0001, 16'b0001);
        chk("t6 cnt_a", cnt_a, 1);
        chk("t6 cnt_b", cnt_b, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
